// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product engine: phase encodings, the
// registered phase-output bundle and the derived phase lengths.
package dot_product_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StInit    = 3'd1,
        StLoad    = 3'd2,
        StGap     = 3'd3,
        StCompute = 3'd4,
        StDone    = 3'd5
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic mem_reset;
        logic comp_reset;
        logic mem_index_reset;
        logic load_from_file;
        logic computing;
    } phase_out_t;

    function automatic int unsigned ram_depth(int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic int unsigned nums_data(int unsigned nums_data_in_bits);
        return 32'd1 << nums_data_in_bits;
    endfunction

    function automatic int unsigned pipeline_tail(int unsigned stages);
        return stages - 32'd1;
    endfunction

    function automatic int unsigned load_cycles(int unsigned depth, int unsigned para_deg);
        return depth / para_deg;
    endfunction

    // One extra cycle so the last element drains through the pipeline tail.
    function automatic int unsigned compute_cycles(int unsigned n_data, int unsigned tail,
                                                   int unsigned para_deg);
        return (n_data + tail) / para_deg + 32'd1;
    endfunction

    // Memory-controller phase inputs for a given state.
    function automatic phase_out_t decode_state(state_e s);
        phase_out_t o;
        o = '0;
        case (s)
            StInit: begin
                o.busy            = 1'b1;
                o.mem_reset       = 1'b1;
                o.comp_reset      = 1'b1;
                o.mem_index_reset = 1'b1;
            end
            StLoad: begin
                o.busy           = 1'b1;
                o.load_from_file = 1'b1;
            end
            StGap: begin
                o.busy       = 1'b1;
                o.comp_reset = 1'b1;
            end
            StCompute: begin
                o.busy      = 1'b1;
                o.computing = 1'b1;
            end
            StDone: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
module phase_counter #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_val_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_val_i);

endmodule

// File: rtl/dot_product_sequencer.sv
// Phase sequencer for the dot-product engine: on start it walks the memory
// controller through clear, load, compute and done. Outputs are registered
// decodes of the next state, so they are valid in the cycle a state is entered.
// Optional build macro DOT_SEQ_SKIP_LOAD_EN adds skip_load, which bypasses
// LOAD for a recompute over already-loaded SRAM.
module dot_product_sequencer
    import dot_product_pkg::*;
#(
    parameter int unsigned Addr_Width           = 4,
    parameter int unsigned Nums_Data_in_bits    = 4,
    parameter int unsigned Nums_Pipeline_Stages = 4,
    parameter int unsigned Para_Deg             = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
`ifdef DOT_SEQ_SKIP_LOAD_EN
    input  logic       skip_load,
`endif
    output logic       busy,
    output logic       done,
    output logic       Mem_reset,
    output logic       Comp_reset,
    output logic       Mem_Index_reset,
    output logic       load_from_file,
    output logic       Computing,
    output logic [2:0] state_out
);

    localparam int unsigned Ram_Depth      = ram_depth(Addr_Width);
    localparam int unsigned Nums_Data      = nums_data(Nums_Data_in_bits);
    localparam int unsigned Pipeline_Tail  = pipeline_tail(Nums_Pipeline_Stages);
    localparam int unsigned Load_Cycles    = load_cycles(Ram_Depth, Para_Deg);
    localparam int unsigned Compute_Cycles = compute_cycles(Nums_Data, Pipeline_Tail, Para_Deg);
    localparam int unsigned Cnt_Width      = Addr_Width + Nums_Data_in_bits + 1;

    state_e               state_q, state_d;
    phase_out_t           outs_q, outs_d;
    logic                 cnt_en, cnt_clr, cnt_tc;
    logic [Cnt_Width-1:0] term_val;
    logic                 skip_run;
    logic                 start_ok;

    // abort takes priority over start in IDLE.
    assign start_ok = (state_q == StIdle) && start && !abort;

`ifdef DOT_SEQ_SKIP_LOAD_EN
    logic skip_q, skip_d;

    // Capture skip_load with the accepted start and hold it for the run.
    always_comb begin
        skip_d = skip_q;
        if (start_ok) begin
            skip_d = skip_load;
        end
    end

    // Skip-load register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end

    assign skip_run = skip_q;
`else
    assign skip_run = 1'b0;
`endif

    // Counter runs only in the two counted phases and sits at zero elsewhere,
    // so it always starts a phase from 0.
    assign cnt_en   = (state_q == StLoad) || (state_q == StCompute);
    assign cnt_clr  = !cnt_en;
    assign term_val = (state_q == StLoad) ? Cnt_Width'(Load_Cycles - 1)
                                          : Cnt_Width'(Compute_Cycles - 1);

    phase_counter #(
        .Width (Cnt_Width)
    ) u_phase_counter (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .clr_i      (cnt_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (cnt_en),
        .term_val_i (term_val),
        .tc_o       (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start_ok) state_d = StInit;
            StInit:    state_d = skip_run ? StGap : StLoad;
            StLoad:    if (cnt_tc) state_d = StGap;
            StGap:     state_d = StCompute;
            StCompute: if (cnt_tc) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // Output decode of the next state.
    always_comb begin
        outs_d = decode_state(state_d);
    end

    // Output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outs_q <= '0;
        end else begin
            outs_q <= outs_d;
        end
    end

    assign busy            = outs_q.busy;
    assign done            = outs_q.done;
    assign Mem_reset       = outs_q.mem_reset;
    assign Comp_reset      = outs_q.comp_reset;
    assign Mem_Index_reset = outs_q.mem_index_reset;
    assign load_from_file  = outs_q.load_from_file;
    assign Computing       = outs_q.computing;
    assign state_out       = state_q;

endmodule
